serial_alu: RTL and testbench
=============================

// Module: serial_alu
// PURPOSE
//  Bit-serial ALU directly downstream of the accumulator shift chain.
//  - Consumes A bit 0 (a_bit) and the operand bit (b_bit), one bit per shift, LSB first.
//  - Produces the result bit (r_bit), which feeds the accumulator MSB input, so A is
//    replaced in place after WIDTH shifts.
//  - Sequences the shifts, holds the carry flop and accumulates the zero flag.
// PARAMETERS
//  WIDTH  12  word length in bits; number of shift cycles per operation (>=2)
// PORTS
//  clk      in   1      single clock; all state changes on rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request operation; sampled only in IDLE
//  op       in   3      opcode, latched with start
//  a_bit    in   1      accumulator bit 0 (current LSB in flight)
//  b_bit    in   1      operand bit 0 from operand shift chain
//  shift    out  1      shift enable to A and operand chains; high in RUN only
//  r_bit    out  1      result bit to accumulator MSB input; valid when shift=1
//  busy     out  1      high in RUN and DONE
//  done     out  1      one-cycle pulse in DONE; flags valid from this cycle
//  carry    out  1      carry/no-borrow flag, held until next start
//  zero     out  1      high when all WIDTH result bits were 0; held until next start
// BEHAVIOUR
//  - Reset: state=IDLE; shift=0, busy=0, done=0, carry=0, zero=0; counter=0; op latch=ADD.
//  - States:
//    - IDLE -(start)-> RUN.
//    - RUN -(count==WIDTH-1)-> DONE.
//    - DONE -> IDLE, unconditionally.
//  - Entering RUN:
//    - Latch op.
//    - count=0.
//    - cin=1 for SUB and INC, else 0.
//    - zero_acc=1.
//  - RUN, each cycle:
//    - shift=1.
//    - r_bit combinational from a_bit, b_bit, cin.
//    - cin <= carry-out.
//    - zero_acc <= zero_acc & ~r_bit.
//    - count++.
//  - Exactly WIDTH shift cycles per operation.
//  - Latency: start high in cycle 0 -> shift high in cycles 1..WIDTH -> done in cycle WIDTH+1
//    -> IDLE in cycle WIDTH+2. Earliest next start is sampled in cycle WIDTH+2.
//  - Ops:
//    - 000 ADD   a+b
//    - 001 SUB   a+~b+1; carry=1 means no borrow
//    - 010 AND   a&b
//    - 011 OR    a|b
//    - 100 XOR   a^b
//    - 101 LOADB b
//    - 110 INC   a+1; b_bit ignored
//    - 111 PASSA a; used as a rotate/readout
//  - carry flag: final cin for ADD/SUB/INC; forced 0 for logic ops, LOADB and PASSA.
//  - Flags update on the RUN->DONE edge only.
//  - start in RUN or DONE is ignored and not queued; op changes after latch are ignored.
//  - rst in any state: next cycle IDLE, shift=0. The partially shifted accumulator is left
//    as is; no completion is reported.
//  - No X propagation: r_bit=0 whenever shift=0.
// STRUCTURE
//  - Shared package:
//    - opcode constants OP_ADD..OP_PASSA (3 bits);
//    - state encoding ST_IDLE/ST_RUN/ST_DONE;
//    - cin-init table (SUB, INC).
//  - One sub-module, serial_alu_bit: pure combinational
//    (a, b, cin, op) -> (r, cout).
//  - Top holds the FSM, counter ($clog2(WIDTH) bits), cin flop, zero_acc and flag registers.
// TESTING
//  Bench models the accumulator and operand chains as WIDTH-bit shift registers driven by
//  shift and r_bit.
//  1. ADD 12'h005 + 12'h003, start 1 cycle -> 12 shift cycles, A=12'h008, done at cycle 13,
//     carry=0, zero=0.
//  2. ADD 12'hFFF + 12'h001 -> A=12'h000, carry=1, zero=1.
//     INC on 12'hFFF -> same result.
//  3. SUB 12'h005 - 12'h007 -> A=12'hFFE, carry=0.
//     SUB 12'h007 - 12'h007 -> A=0, carry=1, zero=1.
//  4. AND 12'hF0F & 12'h0FF -> 12'h00F.
//     XOR with same operands -> 12'hFF0, carry=0.
//     LOADB 12'h123 -> 12'h123.
//  5. start held high through the whole operation -> exactly one operation of 12 shifts.
//     Second start accepted only in IDLE.
//  6. rst asserted at shift 5 of an ADD -> shift=0 next cycle, no done pulse, flags=0.
//     A following ADD completes normally.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states and
// per-opcode carry-in/carry-flag rules.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_LOADB = 3'b101,
        OP_INC   = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // SUB forms a + ~b + 1 and INC forms a + 1, so both start with a carry in.
    function automatic logic cin_init(input op_t o);
        return (o == OP_SUB) || (o == OP_INC);
    endfunction

    function automatic logic op_is_arith(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_INC);
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice: combinational result and carry-out for the bit in flight.
module serial_alu_bit
    import serial_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  op,
    output logic r,
    output logic cout
);

    logic bn;

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        bn   = ~b;
        unique case (op)
            OP_ADD: begin
                r    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                r    = a ^ bn ^ cin;
                cout = (a & bn) | (a & cin) | (bn & cin);
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_LOADB: r = b;
            OP_INC: begin
                r    = a ^ cin;
                cout = a & cin;
            end
            OP_PASSA: r = a;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: sequences WIDTH shifts of the accumulator/operand chains,
// carries between bits and collects carry/zero flags for the finished word.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       shift,
    output logic       r_bit,
    output logic       busy,
    output logic       done,
    output logic       carry,
    output logic       zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_n;
    logic [CNT_W-1:0]   count;
    op_t                op_q;
    logic               cin;
    logic               zero_acc;
    logic               carry_q;
    logic               zero_q;
    logic               alu_r;
    logic               alu_cout;
    logic               last;

    serial_alu_bit u_bit (
        .a    (a_bit),
        .b    (b_bit),
        .cin  (cin),
        .op   (op_q),
        .r    (alu_r),
        .cout (alu_cout)
    );

    assign last = (count == CNT_W'(WIDTH - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (start) state_n = ST_RUN;
            ST_RUN:  if (last)  state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign shift = (state == ST_RUN);
    assign r_bit = shift & alu_r;
    assign busy  = (state == ST_RUN) || (state == ST_DONE);
    assign done  = (state == ST_DONE);
    assign carry = carry_q;
    assign zero  = zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_q     <= OP_ADD;
            cin      <= 1'b0;
            zero_acc <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op_t'(op);
                        count    <= '0;
                        cin      <= cin_init(op_t'(op));
                        zero_acc <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cin      <= alu_cout;
                    zero_acc <= zero_acc & ~alu_r;
                    count    <= count + CNT_W'(1);
                    // Flags take the final bit directly, since zero_acc/cin lag by one cycle.
                    if (last) begin
                        carry_q <= op_is_arith(op_q) & alu_cout;
                        zero_q  <= zero_acc & ~alu_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu with the accumulator and operand chains modelled
// as WIDTH-bit shift registers around the DUT.
module tb_serial_alu;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic         a_bit, b_bit;
    logic         shift, r_bit, busy, done, carry, zero;
    logic [W-1:0] acc, opr, ld_a, ld_b;
    logic         ld = 1'b0;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a_bit (a_bit),
        .b_bit (b_bit),
        .shift (shift),
        .r_bit (r_bit),
        .busy  (busy),
        .done  (done),
        .carry (carry),
        .zero  (zero)
    );

    // Accumulator takes r_bit at its MSB; operand chain rotates so it is restored.
    always @(posedge clk) begin
        if (ld) begin
            acc <= ld_a;
            opr <= ld_b;
        end else if (shift) begin
            acc <= {r_bit, acc[W-1:1]};
            opr <= {opr[0], opr[W-1:1]};
        end
    end

    assign a_bit = acc[0];
    assign b_bit = opr[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        ld   = 1'b1;
        ld_a = a;
        ld_b = b;
        @(negedge clk);
        ld   = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input logic ec, input logic ez);
        int cyc;
        int nsh;
        load(a, b);
        start = 1'b1;
        op    = o;
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        cyc   = 1;
        nsh   = 0;
        while (!done && cyc < 40) begin
            if (shift) nsh++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, cyc, W + 1);
        chk({tag, ".shifts"}, nsh, W);
        chk({tag, ".acc"}, acc, exp);
        chk({tag, ".carry"}, carry, ec);
        chk({tag, ".zero"}, zero, ez);
        @(negedge clk);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int nsh;
        int ndone;

        // Reset with live chain bits to confirm r_bit stays quiet when not shifting.
        load(12'hFFF, 12'hFFF);
        @(negedge clk);
        chk("rst.shift", shift, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.carry", carry, 1'b0);
        chk("rst.zero", zero, 1'b0);
        chk("rst.rbit", r_bit, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.rbit", r_bit, 1'b0);

        run_op("add5p3",  3'b000, 12'h005, 12'h003, 12'h008, 1'b0, 1'b0);
        run_op("addwrap", 3'b000, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b1);
        run_op("inc",     3'b110, 12'hFFF, 12'h5A5, 12'h000, 1'b1, 1'b1);
        run_op("sub5m7",  3'b001, 12'h005, 12'h007, 12'hFFE, 1'b0, 1'b0);
        run_op("sub7m7",  3'b001, 12'h007, 12'h007, 12'h000, 1'b1, 1'b1);
        run_op("and",     3'b010, 12'hF0F, 12'h0FF, 12'h00F, 1'b0, 1'b0);
        run_op("or",      3'b011, 12'hF0F, 12'h0FF, 12'hFFF, 1'b0, 1'b0);
        run_op("xor",     3'b100, 12'hF0F, 12'h0FF, 12'hFF0, 1'b0, 1'b0);
        run_op("loadb",   3'b101, 12'hABC, 12'h123, 12'h123, 1'b0, 1'b0);
        run_op("passa",   3'b111, 12'hABC, 12'h123, 12'hABC, 1'b0, 1'b0);
        run_op("andzero", 3'b010, 12'hF00, 12'h0FF, 12'h000, 1'b0, 1'b1);

        // start held high: one op of W shifts, the re-start only lands from IDLE.
        load(12'h001, 12'h001);
        start = 1'b1;
        op    = 3'b000;
        @(negedge clk);
        cyc = 1;
        nsh = 0;
        while (!done && cyc < 40) begin
            if (shift) nsh++;
            @(negedge clk);
            cyc++;
        end
        chk("hold.latency", cyc, W + 1);
        chk("hold.shifts", nsh, W);
        chk("hold.acc", acc, 12'h002);
        @(negedge clk);
        chk("hold.idle_busy", busy, 1'b0);
        chk("hold.idle_shift", shift, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("hold.restart", shift, 1'b1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold2.latency", cyc, W);
        chk("hold2.acc", acc, 12'h003);
        @(negedge clk);

        // Reset during an ADD at the fifth shift, after flags were left set.
        run_op("presub", 3'b001, 12'h007, 12'h007, 12'h000, 1'b1, 1'b1);
        load(12'h005, 12'h003);
        start = 1'b1;
        op    = 3'b000;
        @(negedge clk);
        start = 1'b0;
        nsh = 0;
        cyc = 0;
        while (nsh < 5 && cyc < 40) begin
            if (shift) nsh++;
            if (nsh < 5) @(negedge clk);
            cyc++;
        end
        chk("rstmid.reach5", nsh, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.shift", shift, 1'b0);
        chk("rstmid.busy", busy, 1'b0);
        chk("rstmid.carry", carry, 1'b0);
        chk("rstmid.zero", zero, 1'b0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("rstmid.nodone", ndone, 0);

        run_op("postrst", 3'b000, 12'h005, 12'h003, 12'h008, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
